// File: rtl/modbus_func_engine.sv
// Modbus RTU function engine: serves 03/04 multi-register reads into the response
// DPRAM and 06 single-register writes with an acknowledge timeout.
module modbus_func_engine #(
    parameter int HOLD_NUM    = 4,
    parameter int INPUT_NUM   = 4,
    parameter int ADDR_BASE   = 1,
    parameter int MAX_QTY     = 16,
    parameter int WAIT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_message_done,
    input  logic [7:0]              func_code,
    input  logic [15:0]             addr,
    input  logic [15:0]             data,
    input  logic                    exception_done,
    input  logic [7:0]              exception_in,
    input  logic [HOLD_NUM*16-1:0]  hold_regs,
    input  logic [INPUT_NUM*16-1:0] input_regs,
    output logic                    dpram_wen,
    output logic [7:0]              dpram_addr,
    output logic [15:0]             dpram_wdata,
    output logic                    reg_wen,
    output logic [7:0]              reg_waddr,
    output logic [15:0]             reg_wdat,
    input  logic                    reg_w_done,
    input  logic                    reg_w_status,
    output logic [7:0]              tx_quantity,
    output logic [7:0]              exception_out,
    output logic                    handler_done
);

    localparam int          TW        = $clog2(WAIT_CYCLES) + 1;
    localparam logic [16:0] BASE17    = 17'(ADDR_BASE);
    localparam logic [16:0] HOLD17    = 17'(HOLD_NUM);
    localparam logic [16:0] INPUT17   = 17'(INPUT_NUM);
    localparam logic [16:0] MAXQ17    = 17'(MAX_QTY);
    localparam logic [TW-1:0] TMO_LAST = TW'(WAIT_CYCLES - 1);

    localparam logic [7:0] EXC_FUNC  = 8'h01;
    localparam logic [7:0] EXC_ADDR  = 8'h02;
    localparam logic [7:0] EXC_VALUE = 8'h03;
    localparam logic [7:0] EXC_DEV   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WREQ,
        S_WWAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_nxt;
    logic [7:0]      func_q;
    logic [15:0]     addr_q;
    logic [15:0]     data_q;
    logic [7:0]      k_q, k_nxt;
    logic [TW-1:0]   timer_q, timer_nxt;
    logic [7:0]      txq_nxt;
    logic [7:0]      exc_nxt;

    // 17-bit so that neither the offset nor offset+quantity can wrap.
    logic [16:0] off17;
    logic [16:0] qty17;
    logic        addr_low;
    logic [7:0]  rd_idx;
    logic [15:0] rd_hold;
    logic [15:0] rd_input;

    assign off17    = {1'b0, addr_q} - BASE17;
    assign qty17    = {1'b0, data_q};
    assign addr_low = ({1'b0, addr_q} < BASE17);
    assign rd_idx   = off17[7:0] + k_q;

    always_comb begin
        rd_hold  = '0;
        rd_input = '0;
        for (int i = 0; i < HOLD_NUM; i++)
            if (rd_idx == 8'(i)) rd_hold = hold_regs[16*i +: 16];
        for (int i = 0; i < INPUT_NUM; i++)
            if (rd_idx == 8'(i)) rd_input = input_regs[16*i +: 16];
    end

    // NOTE: latched request fields are ordinary flops, so they get reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            func_q        <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            k_q           <= '0;
            timer_q       <= '0;
            tx_quantity   <= '0;
            exception_out <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q       <= state_nxt;
            k_q           <= k_nxt;
            timer_q       <= timer_nxt;
            tx_quantity   <= txq_nxt;
            exception_out <= exc_nxt;
            if (state_q == S_IDLE && rx_message_done) begin
                func_q <= func_code;
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no latch is inferred.
        state_nxt    = state_q;
        k_nxt        = k_q;
        timer_nxt    = timer_q;
        txq_nxt      = tx_quantity;
        exc_nxt      = exception_out;
        dpram_wen    = 1'b0;
        dpram_addr   = '0;
        dpram_wdata  = '0;
        reg_wen      = 1'b0;
        reg_waddr    = '0;
        reg_wdat     = '0;
        handler_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exception_done) begin
                    if (exception_in != 8'h00) begin
                        exc_nxt   = exception_in;
                        txq_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                k_nxt     = '0;
                timer_nxt = '0;
                txq_nxt   = '0;
                state_nxt = S_DONE;
                case (func_q)
                    8'h03, 8'h04: begin
                        if (qty17 == 17'd0 || qty17 > MAXQ17)
                            exc_nxt = EXC_VALUE;
                        else if (addr_low ||
                                 (off17 + qty17) > ((func_q == 8'h03) ? HOLD17 : INPUT17))
                            exc_nxt = EXC_ADDR;
                        else
                            state_nxt = S_READ;
                    end
                    8'h06: begin
                        if (addr_low || off17 >= HOLD17)
                            exc_nxt = EXC_ADDR;
                        else
                            state_nxt = S_WREQ;
                    end
                    default: exc_nxt = EXC_FUNC;
                endcase
            end

            S_READ: begin
                dpram_wen   = 1'b1;
                dpram_addr  = k_q;
                dpram_wdata = (func_q == 8'h04) ? rd_input : rd_hold;
                k_nxt       = k_q + 8'd1;
                if (k_q + 8'd1 == data_q[7:0]) begin
                    txq_nxt   = data_q[7:0];
                    exc_nxt   = '0;
                    state_nxt = S_DONE;
                end
            end

            S_WREQ: begin
                reg_wen   = 1'b1;
                reg_waddr = off17[7:0];
                reg_wdat  = data_q;
                timer_nxt = '0;
                state_nxt = S_WWAIT;
            end

            S_WWAIT: begin
                timer_nxt = timer_q + TW'(1);
                if (reg_w_done) begin
                    exc_nxt   = reg_w_status ? EXC_DEV : 8'h00;
                    txq_nxt   = reg_w_status ? 8'd0 : 8'd1;
                    state_nxt = S_DONE;
                end else if (timer_q == TMO_LAST) begin
                    exc_nxt   = EXC_DEV;
                    txq_nxt   = '0;
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                handler_done = 1'b1;
                state_nxt    = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_modbus_func_engine.sv
// Self-checking bench for modbus_func_engine: vector table of requests with a
// DPRAM-word scoreboard, plus write, timeout and mid-read reset sequences.
module tb_modbus_func_engine;

    localparam int HOLD_NUM  = 4;
    localparam int INPUT_NUM = 4;
    localparam int ADDR_BASE = 1;
    localparam int WAIT_CYC  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    rx_message_done;
    logic [7:0]              func_code;
    logic [15:0]             addr;
    logic [15:0]             data;
    logic                    exception_done;
    logic [7:0]              exception_in;
    logic [HOLD_NUM*16-1:0]  hold_regs;
    logic [INPUT_NUM*16-1:0] input_regs;
    logic                    dpram_wen;
    logic [7:0]              dpram_addr;
    logic [15:0]             dpram_wdata;
    logic                    reg_wen;
    logic [7:0]              reg_waddr;
    logic [15:0]             reg_wdat;
    logic                    reg_w_done;
    logic                    reg_w_status;
    logic [7:0]              tx_quantity;
    logic [7:0]              exception_out;
    logic                    handler_done;

    logic [15:0] hold_m  [HOLD_NUM];
    logic [15:0] input_m [INPUT_NUM];

    typedef struct {
        logic [7:0]  func;
        logic [15:0] addr;
        logic [15:0] data;
        logic [7:0]  exc_in;
        logic [7:0]  exp_exc;
        logic [7:0]  exp_txq;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [7:0]  waddr;
        logic [15:0] wdata;
    } word_t;

    vec_t  vecs[14];
    word_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        hold_regs  = '0;
        input_regs = '0;
        for (int i = 0; i < HOLD_NUM; i++)  hold_regs[16*i +: 16]  = hold_m[i];
        for (int i = 0; i < INPUT_NUM; i++) input_regs[16*i +: 16] = input_m[i];
    end

    modbus_func_engine #(
        .HOLD_NUM(HOLD_NUM), .INPUT_NUM(INPUT_NUM), .ADDR_BASE(ADDR_BASE),
        .MAX_QTY(16), .WAIT_CYCLES(WAIT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_message_done(rx_message_done), .func_code(func_code),
        .addr(addr), .data(data),
        .exception_done(exception_done), .exception_in(exception_in),
        .hold_regs(hold_regs), .input_regs(input_regs),
        .dpram_wen(dpram_wen), .dpram_addr(dpram_addr), .dpram_wdata(dpram_wdata),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdat(reg_wdat),
        .reg_w_done(reg_w_done), .reg_w_status(reg_w_status),
        .tx_quantity(tx_quantity), .exception_out(exception_out),
        .handler_done(handler_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [7:0] func, input int idx);
        return (func == 8'h04) ? input_m[idx] : hold_m[idx];
    endfunction

    // Pulses rx_message_done, then exception_done (cycle 0); returns at the sampling edge of cycle 0.
    task automatic send(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                        input logic [7:0] ein);
        @(negedge clk);
        rx_message_done = 1'b1; func_code = f; addr = a; data = d;
        @(negedge clk);
        rx_message_done = 1'b0; exception_done = 1'b1; exception_in = ein;
        @(posedge clk);
    endtask

    task automatic run_req(input vec_t v, input string nm);
        word_t w;
        bit    done_seen = 0;
        int    t = 0;
        if (v.exp_exc == 8'h00 && (v.func == 8'h03 || v.func == 8'h04))
            for (int i = 0; i < int'(v.data); i++) begin
                w.waddr = 8'(i);
                w.wdata = model_word(v.func, int'(v.addr) - ADDR_BASE + i);
                sb.push_back(w);
            end
        send(v.func, v.addr, v.data, v.exc_in);
        while (!done_seen && t < 60) begin
            @(negedge clk);
            t++;
            exception_done = 1'b0; exception_in = '0;
            if (dpram_wen) begin
                if (sb.size() == 0) check({nm, " unexpected dpram write"}, 64'(dpram_wen), 0);
                else begin
                    w = sb.pop_front();
                    check({nm, " dpram_addr"}, 64'(dpram_addr), 64'(w.waddr));
                    check({nm, " dpram_wdata"}, 64'(dpram_wdata), 64'(w.wdata));
                end
            end
            if (handler_done) begin
                done_seen = 1;
                check({nm, " done cycle"}, 64'(t), 64'(v.exp_cyc));
                check({nm, " tx_quantity"}, 64'(tx_quantity), 64'(v.exp_txq));
                check({nm, " exception_out"}, 64'(exception_out), 64'(v.exp_exc));
            end
        end
        check({nm, " handler_done seen"}, 64'(done_seen), 1);
        check({nm, " words left"}, 64'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic run_write(input logic [15:0] a, input logic [15:0] d, input int ack_cyc,
                             input logic status, input logic [7:0] exp_exc,
                             input logic [7:0] exp_txq, input int exp_cyc, input string nm);
        bit done_seen = 0;
        int t = 0;
        int wen_cnt = 0;
        send(8'h06, a, d, 8'h00);
        while (!done_seen && t < 60) begin
            @(negedge clk);
            t++;
            exception_done = 1'b0; exception_in = '0;
            reg_w_done = 1'b0; reg_w_status = 1'b0;
            if (reg_wen) begin
                wen_cnt++;
                check({nm, " reg_wen cycle"}, 64'(t), 2);
                check({nm, " reg_waddr"}, 64'(reg_waddr), 64'(int'(a) - ADDR_BASE));
                check({nm, " reg_wdat"}, 64'(reg_wdat), 64'(d));
            end
            if (handler_done) begin
                done_seen = 1;
                check({nm, " done cycle"}, 64'(t), 64'(exp_cyc));
                check({nm, " tx_quantity"}, 64'(tx_quantity), 64'(exp_txq));
                check({nm, " exception_out"}, 64'(exception_out), 64'(exp_exc));
            end else if (t == ack_cyc) begin
                reg_w_done = 1'b1; reg_w_status = status;
            end
        end
        check({nm, " handler_done seen"}, 64'(done_seen), 1);
        check({nm, " reg_wen pulses"}, 64'(wen_cnt), 1);
    endtask

    initial begin
        int quiet;
        hold_m  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        input_m = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};

        //           func   addr      data     exc_in exp_exc exp_txq cyc
        vecs[0]  = '{8'h03, 16'd1,    16'd3,   8'h00, 8'h00,  8'd3,   5};
        vecs[1]  = '{8'h04, 16'd4,    16'd1,   8'h00, 8'h00,  8'd1,   3};
        vecs[2]  = '{8'h04, 16'd4,    16'd2,   8'h00, 8'h02,  8'd0,   2};
        vecs[3]  = '{8'h03, 16'd1,    16'd0,   8'h00, 8'h03,  8'd0,   2};
        vecs[4]  = '{8'h03, 16'd1,    16'd17,  8'h00, 8'h03,  8'd0,   2};
        vecs[5]  = '{8'h05, 16'd1,    16'd1,   8'h00, 8'h01,  8'd0,   2};
        vecs[6]  = '{8'h03, 16'd2,    16'd3,   8'h00, 8'h00,  8'd3,   5};
        vecs[7]  = '{8'h03, 16'd1,    16'd1,   8'h02, 8'h02,  8'd0,   1};
        vecs[8]  = '{8'h04, 16'd1,    16'd4,   8'h00, 8'h00,  8'd4,   6};
        vecs[9]  = '{8'h03, 16'd0,    16'd1,   8'h00, 8'h02,  8'd0,   2};
        vecs[10] = '{8'h03, 16'd1,    16'd16,  8'h00, 8'h02,  8'd0,   2};
        vecs[11] = '{8'h06, 16'd5,    16'h1234,8'h00, 8'h02,  8'd0,   2};
        vecs[12] = '{8'h06, 16'd0,    16'h1234,8'h00, 8'h02,  8'd0,   2};
        vecs[13] = '{8'h03, 16'hFFFF, 16'd1,   8'h00, 8'h02,  8'd0,   2};

        rst_n = 1'b0; rx_message_done = 1'b0; func_code = '0; addr = '0; data = '0;
        exception_done = 1'b0; exception_in = '0; reg_w_done = 1'b0; reg_w_status = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl outputs", {dpram_wen, reg_wen, handler_done, tx_quantity, exception_out}, 0);
        check("reset data outputs", {dpram_addr, dpram_wdata, reg_waddr, reg_wdat}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        run_write(16'd2, 16'hBEEF, 7, 1'b0, 8'h00, 8'd1, 8, "write ok");
        run_write(16'd2, 16'hBEEF, 7, 1'b1, 8'h04, 8'd0, 8, "write status1");
        run_write(16'd3, 16'h5A5A, -1, 1'b0, 8'h04, 8'd0, 3 + WAIT_CYC, "write timeout");

        // Late acknowledge arriving in IDLE must not start or finish anything.
        @(negedge clk); reg_w_done = 1'b1;
        @(negedge clk); reg_w_done = 1'b0;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            quiet += int'(handler_done) + int'(reg_wen) + int'(dpram_wen);
        end
        check("late ack ignored", 64'(quiet), 0);
        run_write(16'd4, 16'h0F0F, 4, 1'b0, 8'h00, 8'd1, 5, "write after late ack");

        // Reset during the second read word.
        send(8'h03, 16'd1, 16'd3, 8'h00);
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            exception_done = 1'b0;
        end
        check("pre-reset dpram_wen", 64'(dpram_wen), 1);
        check("pre-reset dpram_addr", 64'(dpram_addr), 1);
        rst_n = 1'b0;
        #1;
        check("mid-read reset ctrl", {dpram_wen, reg_wen, handler_done, tx_quantity, exception_out}, 0);
        check("mid-read reset data", {dpram_addr, dpram_wdata, reg_waddr, reg_wdat}, 0);
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            quiet += int'(handler_done);
        end
        check("no done during reset", 64'(quiet), 0);
        rst_n = 1'b1;
        run_req(vecs[0], "read after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
